// File: rtl/op_lut_dst_port_writer_pkg.sv
// Shared definitions for the output-port lookup writer: FSM encoding and
// the positions of the port fields inside the stream sideband.
package op_lut_dst_port_writer_pkg;

  typedef enum logic [1:0] {
    WAIT_DEC = 2'd0,
    SEND_PKT = 2'd1,
    DROP_PKT = 2'd2
  } state_e;

  localparam int SRC_PORT_POS = 16;
  localparam int DST_PORT_POS = 24;

endpackage

// File: rtl/op_lut_dst_port_writer_fifo.sv
// Small first-word-fall-through FIFO: dout always shows the head entry,
// rd_en acknowledges it. nearly_full leaves one slot of slack for the writer.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_CNT = {1'b1, {MAX_DEPTH_BITS{1'b0}}};
  localparam logic [MAX_DEPTH_BITS:0] NF_CNT   = {1'b0, {MAX_DEPTH_BITS{1'b1}}};

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      full, do_wr, do_rd;

  assign full        = (count == FULL_CNT);
  assign nearly_full = (count >= NF_CNT);
  assign empty       = (count == '0);
  assign do_wr       = wr_en && !full;
  assign do_rd       = rd_en && !empty;
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/op_lut_dst_port_writer.sv
// Buffers ingress packets, pops one forwarding decision per packet and either
// forwards the packet with the destination port stamped into word 0, or drains it.
module op_lut_dst_port_writer
  import op_lut_dst_port_writer_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES           = 8,
  parameter int PKT_FIFO_DEPTH_BITS  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  input  logic [NUM_QUEUES-1:0]             dec_dst_port,
  input  logic                              dec_drop,
  input  logic                              dec_vld,
  output logic                              dec_rd,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic                              pkt_sent,
  output logic                              pkt_dropped
);

  localparam int DW     = C_S_AXIS_DATA_WIDTH;
  localparam int SW     = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW     = C_S_AXIS_TUSER_WIDTH;
  localparam int FIFO_W = DW + SW + UW + 1;

  state_e                state, state_nxt;
  logic [NUM_QUEUES-1:0] dst_q;
  logic                  first_q;

  logic [FIFO_W-1:0]     fifo_dout;
  logic                  fifo_rd, fifo_nf, fifo_empty, fifo_wr;
  logic [DW-1:0]         f_data;
  logic [SW-1:0]         f_strb;
  logic [UW-1:0]         f_user;
  logic                  f_last;

  assign fifo_wr       = s_axis_tvalid && s_axis_tready;
  assign s_axis_tready = !fifo_nf && !reset;

  fallthrough_small_fifo #(
    .WIDTH          (FIFO_W),
    .MAX_DEPTH_BITS (PKT_FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .din         ({s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata}),
    .wr_en       (fifo_wr),
    .rd_en       (fifo_rd),
    .dout        (fifo_dout),
    .nearly_full (fifo_nf),
    .empty       (fifo_empty)
  );

  assign {f_last, f_user, f_strb, f_data} = fifo_dout;

  assign m_axis_tdata = f_data;
  assign m_axis_tstrb = f_strb;
  assign m_axis_tlast = f_last;

  always_comb begin
    m_axis_tuser = f_user;
    if (first_q) m_axis_tuser[DST_PORT_POS +: NUM_QUEUES] = dst_q;
  end

  always_comb begin
    state_nxt     = state;
    dec_rd        = 1'b0;
    m_axis_tvalid = 1'b0;
    fifo_rd       = 1'b0;
    pkt_sent      = 1'b0;
    pkt_dropped   = 1'b0;
    case (state)
      WAIT_DEC: begin
        // Decision only popped once the packet it belongs to has arrived.
        if (dec_vld && !fifo_empty) begin
          dec_rd    = 1'b1;
          state_nxt = (dec_drop || dec_dst_port == '0) ? DROP_PKT : SEND_PKT;
        end
      end
      SEND_PKT: begin
        m_axis_tvalid = !fifo_empty;
        if (!fifo_empty && m_axis_tready) begin
          fifo_rd = 1'b1;
          if (f_last) begin
            pkt_sent  = 1'b1;
            state_nxt = WAIT_DEC;
          end
        end
      end
      DROP_PKT: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          if (f_last) begin
            pkt_dropped = 1'b1;
            state_nxt   = WAIT_DEC;
          end
        end
      end
      default: state_nxt = WAIT_DEC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_DEC;
    else       state <= state_nxt;
  end

  // first_q marks the head word as the first of the packet being sent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst_q   <= '0;
      first_q <= 1'b0;
    end else begin
      if (dec_rd) begin
        dst_q   <= dec_dst_port;
        first_q <= 1'b1;
      end else if (fifo_rd) begin
        first_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_op_lut_dst_port_writer.sv
// Randomized scoreboard bench for op_lut_dst_port_writer.
module tb_op_lut_dst_port_writer;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int NQ = 8;
  localparam int SW = DW / 8;

  logic          clk, reset;
  logic [DW-1:0] s_axis_tdata;
  logic [SW-1:0] s_axis_tstrb;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [NQ-1:0] dec_dst_port;
  logic          dec_drop, dec_vld, dec_rd;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic          pkt_sent, pkt_dropped;

  op_lut_dst_port_writer #(
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .NUM_QUEUES           (NQ),
    .PKT_FIFO_DEPTH_BITS  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .dec_dst_port  (dec_dst_port),
    .dec_drop      (dec_drop),
    .dec_vld       (dec_vld),
    .dec_rd        (dec_rd),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .pkt_sent      (pkt_sent),
    .pkt_dropped   (pkt_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [UW-1:0] u;
    logic          l;
  } word_t;

  word_t exp_q[$];
  int checks = 0, passes = 0;
  int n_dec = 0, n_sent = 0, n_drop = 0, n_nf = 0;
  int exp_dec = 0, exp_sent = 0, exp_drop = 0;
  int rdy_mode = 1;

  task automatic chk(string name, logic [255:0] act, logic [255:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Decision source: in-order list of per-packet decisions, popped on dec_rd.
  logic [NQ-1:0] dq_dst [256];
  logic          dq_drop[256];
  logic [7:0]    dq_wr = 8'd0, dq_rd;
  assign dec_vld      = (dq_wr != dq_rd);
  assign dec_dst_port = dq_dst[dq_rd];
  assign dec_drop     = dq_drop[dq_rd];
  always @(posedge clk or posedge reset)
    if (reset) dq_rd <= 8'd0;
    else if (dec_rd) dq_rd <= dq_rd + 8'd1;

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted output word.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_d;
  logic [UW-1:0] stall_u;
  always @(negedge clk) begin
    if (reset) stall_prev = 1'b0;
    else begin
      if (dec_rd) n_dec++;
      if (pkt_sent) n_sent++;
      if (pkt_dropped) n_drop++;
      if (!s_axis_tready) n_nf++;
      if (stall_prev) begin
        chk("stall_valid", 256'(m_axis_tvalid), 256'(1));
        chk("stall_data", m_axis_tdata ^ stall_d, 256'(0));
        chk("stall_user", 256'(m_axis_tuser ^ stall_u), 256'(0));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 256'(1), 256'(0));
        else begin
          word_t e;
          e = exp_q.pop_front();
          chk("tdata", m_axis_tdata, e.d);
          chk("tstrb", 256'(m_axis_tstrb), 256'(e.s));
          chk("tuser", 256'(m_axis_tuser), 256'(e.u));
          chk("tlast", 256'(m_axis_tlast), 256'(e.l));
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_d    = m_axis_tdata;
      stall_u    = m_axis_tuser;
    end
  end

  function automatic logic [DW-1:0] rand_d();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [UW-1:0] rand_u();
    logic [UW-1:0] r;
    for (int i = 0; i < UW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_word(word_t w);
    int t;
    s_axis_tdata  = w.d;
    s_axis_tstrb  = w.s;
    s_axis_tuser  = w.u;
    s_axis_tlast  = w.l;
    s_axis_tvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      t++;
      if (t > 3000) begin
        $display("FAIL ingress_timeout: got stalled expected accept");
        $fatal(1);
      end
    end
    @(posedge clk); #1;
  endtask

  // Reference model: a packet appears on the output only when the decision
  // forwards it; its first word carries the destination in tuser[31:24].
  task automatic send_pkt(int len, logic [NQ-1:0] dst, logic drop, logic zero_field);
    logic  fwd;
    word_t w, e;
    fwd = !drop && (dst != '0);
    dq_dst[dq_wr]  = dst;
    dq_drop[dq_wr] = drop;
    dq_wr++;
    exp_dec++;
    if (fwd) exp_sent++; else exp_drop++;
    for (int i = 0; i < len; i++) begin
      w.d = rand_d();
      w.s = SW'({$urandom, $urandom});
      w.u = rand_u();
      if (zero_field) w.u[31:24] = 8'h00;
      w.l = (i == len - 1);
      if (fwd) begin
        e = w;
        if (i == 0) e.u[31:24] = dst;
        exp_q.push_back(e);
      end
      drive_word(w);
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain_and_count(string tag, int b_dec, int b_sent, int b_drop);
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin @(posedge clk); t++; end
    repeat (40) @(posedge clk);
    #1;
    chk({tag, "_drained"}, 256'(exp_q.size()), 256'(0));
    chk({tag, "_dec_rd"},  256'(n_dec - b_dec),   256'(exp_dec));
    chk({tag, "_sent"},    256'(n_sent - b_sent), 256'(exp_sent));
    chk({tag, "_dropped"}, 256'(n_drop - b_drop), 256'(exp_drop));
  endtask

  initial begin
    int    b_nf, b_dec, b_sent, b_drop;
    word_t w;
    reset = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", 256'(s_axis_tready), 256'(0));
    chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
    chk("rst_dec_rd",   256'(dec_rd),        256'(0));
    chk("rst_sent",     256'(pkt_sent),      256'(0));
    chk("rst_dropped",  256'(pkt_dropped),   256'(0));
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));

    // Directed cases: basic send, drop flag, zero destination, back-to-back singles.
    rdy_mode = 1;
    send_pkt(3, 8'h04, 1'b0, 1'b1);
    send_pkt(2, 8'h10, 1'b1, 1'b0);
    send_pkt(2, 8'h02, 1'b0, 1'b0);
    send_pkt(3, 8'h00, 1'b0, 1'b0);
    send_pkt(1, 8'h01, 1'b0, 1'b0);
    send_pkt(1, 8'h40, 1'b0, 1'b0);

    // Long packet against a stalled egress: ingress must throttle.
    b_nf = n_nf;
    fork
      send_pkt(40, 8'h08, 1'b0, 1'b0);
      begin
        rdy_mode = 0;
        repeat (20) @(posedge clk);
        rdy_mode = 1;
      end
    join
    chk("ingress_throttled", 256'(n_nf > b_nf), 256'(1));

    // Random traffic with random egress backpressure.
    rdy_mode = 2;
    for (int p = 0; p < 30; p++) begin
      int r;
      logic [NQ-1:0] dst;
      r   = $urandom_range(0, 9);
      dst = (r == 1) ? 8'h00 : 8'($urandom_range(1, 255));
      send_pkt($urandom_range(1, 6), dst, r == 0, 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end
    drain_and_count("phase1", 0, 0, 0);

    // Abort a packet with reset after two words, egress held off.
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    dq_dst[dq_wr] = 8'h20; dq_drop[dq_wr] = 1'b0; dq_wr++;
    for (int i = 0; i < 2; i++) begin
      w.d = rand_d(); w.s = '1; w.u = rand_u(); w.l = 1'b0;
      drive_word(w);
    end
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async_rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
    chk("async_rst_s_tready", 256'(s_axis_tready), 256'(0));
    chk("async_rst_dec_rd",   256'(dec_rd),        256'(0));
    chk("async_rst_sent",     256'(pkt_sent),      256'(0));
    chk("async_rst_dropped",  256'(pkt_dropped),   256'(0));
    s_axis_tvalid = 1'b0;
    dq_wr = 8'd0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    b_dec = n_dec; b_sent = n_sent; b_drop = n_drop;
    exp_dec = 0; exp_sent = 0; exp_drop = 0;
    @(posedge clk); #1;
    rdy_mode = 2;
    send_pkt(3, 8'h80, 1'b0, 1'b0);
    send_pkt(2, 8'h03, 1'b1, 1'b0);
    send_pkt(1, 8'h05, 1'b0, 1'b0);
    drain_and_count("phase2", b_dec, b_sent, b_drop);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/op_lut_dst_port_writer.md
OP_LUT_DST_PORT_WRITER -- requirements
Module: op_lut_dst_port_writer

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, stream data width.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, stream sideband width.
REQ-003 SHALL have parameter NUM_QUEUES, default 8, one-hot port-vector width.
REQ-004 SHALL have parameter PKT_FIFO_DEPTH_BITS, default 4, log2 depth of the internal word buffer.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, as ports clk and reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 s_axis_tdata / s_axis_tstrb / s_axis_tuser  input  DATA / DATA/8 / TUSER  ingress packet word.
REQ-009 s_axis_tvalid, s_axis_tlast  input  1 each; s_axis_tready  output  1.
REQ-010 dec_dst_port  input  NUM_QUEUES  one-hot or multi-hot destination for the head packet.
REQ-011 dec_drop  input  1  head packet is to be discarded.
REQ-012 dec_vld  input  1  decision available (fall-through, non-empty); dec_rd  output  1  pop decision.
REQ-013 m_axis_tdata / m_axis_tstrb / m_axis_tuser / m_axis_tvalid / m_axis_tlast  output; m_axis_tready  input.
REQ-014 pkt_sent, pkt_dropped  output  1 each  single-cycle statistics pulses.

Function
REQ-015 Ingress words SHALL be written to the word buffer on s_axis_tvalid && s_axis_tready; s_axis_tready = !buffer nearly_full.
REQ-016 FSM states SHALL be WAIT_DEC, SEND_PKT, DROP_PKT; reset state WAIT_DEC.
REQ-017 WAIT_DEC: when dec_vld && buffer non-empty, dec_rd SHALL pulse for exactly one cycle and the decision SHALL be latched.
REQ-018 Latched decision with dec_drop=1 or dec_dst_port=0 SHALL go to DROP_PKT; otherwise SHALL go to SEND_PKT.
REQ-019 dec_rd SHALL never be asserted outside WAIT_DEC, and at most once per packet.
REQ-020 SEND_PKT: m_axis_tvalid = buffer non-empty; buffer pops on m_axis_tvalid && m_axis_tready; m_axis_* data/strb/last driven from buffer head.
REQ-021 First word of each sent packet SHALL carry m_axis_tuser[24+NUM_QUEUES-1:24] = latched dec_dst_port; all other tuser bits and all later words unchanged.
REQ-022 First output word SHALL be presentable the cycle after dec_rd (latency 1 from decision pop).
REQ-023 Accepted output word with tlast SHALL return FSM to WAIT_DEC and pulse pkt_sent for one cycle.
REQ-024 DROP_PKT: m_axis_tvalid SHALL stay 0; buffer SHALL pop one word per cycle while non-empty; popped tlast returns to WAIT_DEC with one pkt_dropped pulse.
REQ-025 Output data SHALL remain stable while m_axis_tvalid && !m_axis_tready.
REQ-026 Ingress SHALL continue filling the buffer during SEND_PKT/DROP_PKT; back-to-back packets with no idle cycle SHALL be supported.
REQ-027 Single-word packets (first word has tlast) SHALL be both stamped and terminated on that word.
REQ-028 Buffer empty mid-packet SHALL deassert m_axis_tvalid without leaving SEND_PKT.

Reset
REQ-029 Reset SHALL clear FSM to WAIT_DEC, latched decision to 0, buffer to empty, and the word-buffer module SHALL receive the same reset.
REQ-030 During/after reset: s_axis_tready, m_axis_tvalid, dec_rd, pkt_sent, pkt_dropped = 0; m_axis data outputs undefined-but-unused.
REQ-031 Reset mid-packet SHALL discard buffered words and the latched decision; no partial packet is resumed.

Structure
REQ-032 FSM state encodings and tuser port-field offsets (SRC 16, DST 24) SHALL live in the shared op_lut package/header.
REQ-033 Word buffer SHALL be one fallthrough_small_fifo instance, width DATA + DATA/8 + TUSER + 1, depth 2^PKT_FIFO_DEPTH_BITS.

Verification
REQ-034 3-word packet, tuser[31:24]=0x00, decision dst=0x04 drop=0 -> 3 output words, word0 tuser[31:24]=0x04, words1-2 tuser unchanged, one pkt_sent.
REQ-035 Packet with decision drop=1 (dst=0x10) -> no m_axis_tvalid, buffer drained, one pkt_dropped, next packet sent normally.
REQ-036 Decision dst=0x00 drop=0 -> packet dropped, pkt_dropped pulses.
REQ-037 Two back-to-back 1-word packets, dst 0x01 then 0x40, m_axis_tready held 1 -> two output words stamped 0x01, 0x40; dec_rd pulses twice.
REQ-038 m_axis_tready low 20 cycles on 40-word packet -> s_axis_tready falls at nearly_full, no word lost/duplicated, order preserved.
REQ-039 Assert reset at word 2 of 5-word packet -> all outputs 0 asynchronously; next packet after reset stamped with its own decision.
